// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared definitions for the control-bundle pipeline: default group widths,
// bit positions of each control signal inside its group, and the kill FSM states.
package ctrl_pipe_regs_pkg;

    localparam int WB_W_DEF  = 2;
    localparam int MEM_W_DEF = 2;
    localparam int EX_W_DEF  = 4;

    // Bit positions inside each group, for the decoder and datapath
    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EX_ALUOP_HI  = 3;
    localparam int EX_ALUOP_LO  = 2;
    localparam int EX_ALUSRC    = 1;
    localparam int EX_REGDST    = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_KILL = 1'b1
    } kill_st_e;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One control pipeline register: holds when en=0, loads zeros/invalid on a
// bubble or invalid input so control bits are never live without valid.
module pipe_ctrl_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         bubble,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            if (bubble || !d_valid) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else begin
                q       <= d;
                q_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control registers with stall/flush/kill bubble
// insertion, a memory-hold freeze and saturating bubble/flush perf counters.
module ctrl_pipe_regs
    import ctrl_pipe_regs_pkg::*;
#(
    parameter int WB_W      = WB_W_DEF,
    parameter int MEM_W     = MEM_W_DEF,
    parameter int EX_W      = EX_W_DEF,
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WB_W-1:0]  id_wb_i,
    input  logic [MEM_W-1:0] id_mem_i,
    input  logic [EX_W-1:0]  id_ex_i,
    input  logic             id_valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_hold_i,
    input  logic             cnt_clr_i,
    output logic             id_accept_o,
    output logic [EX_W-1:0]  ex_ex_o,
    output logic [MEM_W-1:0] ex_mem_o,
    output logic [WB_W-1:0]  ex_wb_o,
    output logic             ex_valid_o,
    output logic [MEM_W-1:0] mem_mem_o,
    output logic [WB_W-1:0]  mem_wb_o,
    output logic             mem_valid_o,
    output logic [WB_W-1:0]  wb_wb_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int KW      = $clog2(FLUSH_LEN) + 1;
    localparam int IDEX_W  = EX_W + MEM_W + WB_W;
    localparam int EXMEM_W = MEM_W + WB_W;

    logic                adv;
    logic                forced;
    logic [KW-1:0]       kill_cnt;
    logic [KW-1:0]       kill_nxt;
    kill_st_e            st;
    logic [IDEX_W-1:0]   idex_q;
    logic [EXMEM_W-1:0]  exmem_q;

    assign adv         = !mem_hold_i;
    assign id_accept_o = !mem_hold_i && !stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) kill_cnt <= '0;
        else       kill_cnt <= kill_nxt;
    end

    // Flush restarts the window; a stall inside it bubbles without consuming a kill
    always_comb begin
        st       = (kill_cnt != '0) ? ST_KILL : ST_IDLE;
        kill_nxt = kill_cnt;
        forced   = 1'b0;
        if (adv) begin
            if (flush_i) begin
                forced   = 1'b1;
                kill_nxt = KW'(FLUSH_LEN - 1);
            end else if (st == ST_KILL) begin
                forced = 1'b1;
                if (!stall_i) kill_nxt = kill_cnt - KW'(1);
            end else if (stall_i) begin
                forced = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else if (adv) begin
            if (forced && !(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
            if (flush_i && !(&flush_cnt_o)) flush_cnt_o  <= flush_cnt_o + CNT_W'(1);
        end
    end

    pipe_ctrl_stage #(.W(IDEX_W)) u_idex (
        .clk(clk_i), .rst(rst_i), .en(adv), .bubble(forced),
        .d({id_ex_i, id_mem_i, id_wb_i}), .d_valid(id_valid_i),
        .q(idex_q), .q_valid(ex_valid_o)
    );

    pipe_ctrl_stage #(.W(EXMEM_W)) u_exmem (
        .clk(clk_i), .rst(rst_i), .en(adv), .bubble(1'b0),
        .d(idex_q[EXMEM_W-1:0]), .d_valid(ex_valid_o),
        .q(exmem_q), .q_valid(mem_valid_o)
    );

    pipe_ctrl_stage #(.W(WB_W)) u_memwb (
        .clk(clk_i), .rst(rst_i), .en(adv), .bubble(1'b0),
        .d(exmem_q[WB_W-1:0]), .d_valid(mem_valid_o),
        .q(wb_wb_o), .q_valid(wb_valid_o)
    );

    assign {ex_ex_o, ex_mem_o, ex_wb_o} = idex_q;
    assign {mem_mem_o, mem_wb_o}        = exmem_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Randomized + directed bench: two configurations (FLUSH_LEN=1/CNT_W=16 and
// FLUSH_LEN=3/CNT_W=4) driven in lockstep and compared to a bundle-level model.
module tb_ctrl_pipe_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] wb, mem;
    logic [3:0] ex;
    logic       v, st, fl, mh, clr;

    logic        acc0, exv0, memv0, wbv0, acc1, exv1, memv1, wbv1;
    logic [3:0]  exex0, exex1;
    logic [1:0]  exmem0, exwb0, memmem0, memwb0, wbwb0;
    logic [1:0]  exmem1, exwb1, memmem1, memwb1, wbwb1;
    logic [15:0] bc0, fc0;
    logic [3:0]  bc1, fc1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic       v;
    } bnd_t;

    bnd_t pe[2], pm[2], pw[2];
    int   kills_left[2], nb[2], nf[2];

    always #5 clk = ~clk;

    ctrl_pipe_regs u0 (
        .clk_i(clk), .rst_i(rst), .id_wb_i(wb), .id_mem_i(mem), .id_ex_i(ex),
        .id_valid_i(v), .stall_i(st), .flush_i(fl), .mem_hold_i(mh), .cnt_clr_i(clr),
        .id_accept_o(acc0), .ex_ex_o(exex0), .ex_mem_o(exmem0), .ex_wb_o(exwb0),
        .ex_valid_o(exv0), .mem_mem_o(memmem0), .mem_wb_o(memwb0), .mem_valid_o(memv0),
        .wb_wb_o(wbwb0), .wb_valid_o(wbv0), .bubble_cnt_o(bc0), .flush_cnt_o(fc0)
    );

    ctrl_pipe_regs #(.FLUSH_LEN(3), .CNT_W(4)) u1 (
        .clk_i(clk), .rst_i(rst), .id_wb_i(wb), .id_mem_i(mem), .id_ex_i(ex),
        .id_valid_i(v), .stall_i(st), .flush_i(fl), .mem_hold_i(mh), .cnt_clr_i(clr),
        .id_accept_o(acc1), .ex_ex_o(exex1), .ex_mem_o(exmem1), .ex_wb_o(exwb1),
        .ex_valid_o(exv1), .mem_mem_o(memmem1), .mem_wb_o(memwb1), .mem_valid_o(memv1),
        .wb_wb_o(wbwb1), .wb_valid_o(wbv1), .bubble_cnt_o(bc1), .flush_cnt_o(fc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flen(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    // One clock of the reference: each ID bundle either survives or is
    // replaced by a bubble, then everything moves down one slot.
    task automatic model_clk();
        bit bub;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pe[d] = '0; pm[d] = '0; pw[d] = '0;
                kills_left[d] = 0; nb[d] = 0; nf[d] = 0;
            end else begin
                if (clr) begin
                    nb[d] = 0; nf[d] = 0;
                end
                if (!mh) begin
                    bub = 1'b0;
                    if (fl) begin
                        bub = 1'b1;
                        kills_left[d] = flen(d) - 1;
                    end else if (kills_left[d] > 0) begin
                        bub = 1'b1;
                        if (!st) kills_left[d]--;
                    end else if (st) begin
                        bub = 1'b1;
                    end
                    pw[d] = pm[d];
                    pm[d] = pe[d];
                    pe[d] = (bub || !v) ? bnd_t'('0) : bnd_t'({ex, mem, wb, 1'b1});
                    if (!clr) begin
                        if (bub && nb[d] < cmax(d)) nb[d]++;
                        if (fl && nf[d] < cmax(d))  nf[d]++;
                    end
                end
            end
        end
    endtask

    task automatic cmp_dut(input int d, input logic [3:0] eex, input logic [1:0] emem,
                           input logic [1:0] ewb, input logic ev, input logic [1:0] mmem,
                           input logic [1:0] mwb, input logic mv, input logic [1:0] wwb,
                           input logic wv, input logic [15:0] b, input logic [15:0] f);
        chk($sformatf("d%0d ex_ex", d),   32'(eex),  pe[d].v ? 32'(pe[d].ex)  : 0);
        chk($sformatf("d%0d ex_mem", d),  32'(emem), pe[d].v ? 32'(pe[d].mem) : 0);
        chk($sformatf("d%0d ex_wb", d),   32'(ewb),  pe[d].v ? 32'(pe[d].wb)  : 0);
        chk($sformatf("d%0d ex_valid", d), 32'(ev),  32'(pe[d].v));
        chk($sformatf("d%0d mem_mem", d), 32'(mmem), pm[d].v ? 32'(pm[d].mem) : 0);
        chk($sformatf("d%0d mem_wb", d),  32'(mwb),  pm[d].v ? 32'(pm[d].wb)  : 0);
        chk($sformatf("d%0d mem_valid", d), 32'(mv), 32'(pm[d].v));
        chk($sformatf("d%0d wb_wb", d),   32'(wwb),  pw[d].v ? 32'(pw[d].wb)  : 0);
        chk($sformatf("d%0d wb_valid", d), 32'(wv),  32'(pw[d].v));
        chk($sformatf("d%0d bubble_cnt", d), 32'(b), 32'(nb[d]));
        chk($sformatf("d%0d flush_cnt", d),  32'(f), 32'(nf[d]));
    endtask

    // Drive at negedge, check combinational accept, clock, check registers.
    task automatic step(input logic r, input logic [3:0] e, input logic [1:0] m,
                        input logic [1:0] w, input logic vv, input logic s,
                        input logic f, input logic h, input logic c);
        rst = r; ex = e; mem = m; wb = w; v = vv; st = s; fl = f; mh = h; clr = c;
        #1;
        if (!r) begin
            chk("d0 id_accept", 32'(acc0), 32'(!h && !s));
            chk("d1 id_accept", 32'(acc1), 32'(!h && !s));
        end
        @(posedge clk);
        model_clk();
        @(negedge clk);
        cmp_dut(0, exex0, exmem0, exwb0, exv0, memmem0, memwb0, memv0, wbwb0, wbv0, bc0, fc0);
        cmp_dut(1, exex1, exmem1, exwb1, exv1, memmem1, memwb1, memv1, wbwb1, wbv1,
                16'(bc1), 16'(fc1));
    endtask

    task automatic rstep(input int p_st, input int p_fl, input int p_mh, input int p_rst);
        step($urandom_range(999, 0) < p_rst, 4'($urandom), 2'($urandom), 2'($urandom),
             $urandom_range(9, 0) < 8, $urandom_range(99, 0) < p_st,
             $urandom_range(99, 0) < p_fl, $urandom_range(99, 0) < p_mh,
             $urandom_range(99, 0) < 3);
    endtask

    task automatic nop(input logic vv);
        step(0, 4'h3, 2'b10, 2'b01, vv, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; ex = '0; mem = '0; wb = '0; v = 0; st = 0; fl = 0; mh = 0; clr = 0;
        @(negedge clk);

        // reset with random inputs, then one bundle walks down the pipe
        for (int i = 0; i < 2; i++)
            step(1, 4'($urandom), 2'($urandom), 2'($urandom), 1, $urandom_range(1, 0),
                 $urandom_range(1, 0), 0, 0);
        chk("rst ex_valid", 32'(exv1), 0);
        chk("rst bubble_cnt", 32'(bc0), 0);
        step(0, 4'hA, 2'b01, 2'b11, 1, 0, 0, 0, 0);
        chk("lat1 ex_ex", 32'(exex0), 32'hA);
        nop(0);
        chk("lat2 mem_mem", 32'(memmem0), 32'h1);
        nop(0);
        chk("lat3 wb_wb", 32'(wbwb1), 32'h3);

        // single-cycle stall
        step(0, 4'h5, 2'b10, 2'b01, 1, 1, 0, 0, 0);
        chk("stall ex_valid", 32'(exv0), 0);
        chk("stall bubble_cnt", 32'(bc0), 1);
        step(0, 4'h5, 2'b10, 2'b01, 1, 0, 0, 0, 0);
        chk("stall release ex_ex", 32'(exex0), 32'h5);

        // flush window of 3 on u1, 1 on u0
        step(0, 4'h1, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        step(0, 4'h7, 2'b11, 2'b10, 1, 0, 1, 0, 0);
        chk("flush u1 bub0", 32'(exv1), 0);
        nop(1);
        chk("flush u1 bub1", 32'(exv1), 0);
        chk("flush u0 pass", 32'(exv0), 1);
        nop(1);
        chk("flush u1 bub2", 32'(exv1), 0);
        chk("flush u1 bubble_cnt", 32'(bc1), 3);
        chk("flush u1 flush_cnt", 32'(fc1), 1);
        nop(1);
        chk("flush u1 4th pass", 32'(exv1), 1);

        // stall inside the kill window stretches it by one
        step(0, 4'h1, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        step(0, 4'h7, 2'b11, 2'b10, 1, 0, 1, 0, 0);
        step(0, 4'h7, 2'b11, 2'b10, 1, 1, 0, 0, 0);
        nop(1);
        nop(1);
        chk("kill+stall bubble_cnt", 32'(bc1), 4);
        nop(1);
        chk("kill+stall pass", 32'(exv1), 1);

        // mem_hold freeze with flush under hold
        for (int i = 0; i < 5; i++)
            step(0, 4'($urandom), 2'($urandom), 2'($urandom), 1, $urandom_range(1, 0),
                 i == 2, 1, 0);
        nop(1);

        // flush+stall together, then re-flush inside KILL
        step(0, 4'h9, 2'b01, 2'b01, 1, 1, 1, 0, 0);
        nop(1);
        step(0, 4'h9, 2'b01, 2'b01, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) nop(1);

        // saturation at CNT_W=4, then clear beats increment
        step(0, 4'h1, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 4'h2, 2'b01, 2'b10, 1, 1, 0, 0, 0);
        chk("sat bubble_cnt", 32'(bc1), 32'hF);
        step(0, 4'h2, 2'b01, 2'b10, 1, 1, 0, 0, 1);
        chk("clr bubble_cnt", 32'(bc1), 0);

        // random traffic
        for (int i = 0; i < 400; i++) rstep(20, 10, 10, 5);
        for (int i = 0; i < 200; i++) rstep(40, 30, 20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
